serial_tx: RTL and testbench

SERIAL_TX -- requirements
Module: serial_tx

---
 rtl/serial_tx.sv | 257 +++++++++++++++++++++++++
 tb/tb_serial_tx.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_tx.sv
// -----------------------------------------------------------------------------
// serial_tx -- memory-mapped serial transmitter with a one-deep holding register.
//
// A CPU writes a payload to the data register (BASE). The payload waits in a
// holding register until the shifter is free. It is then sent on txd as one
// start bit (0), DATA_WIDTH data bits LSB first, and one stop bit (1). Each bit
// lasts CLKS_PER_BIT clocks.
//
// Ports
//   clk         sole clock, rising edge
//   reset       asynchronous, active-high reset
//   we, re      bus write / read strobes
//   memAddr     bus address
//   dataBusIn   bus write data
//   dataBusOut  bus read data (combinational)
//   txd         serial line, registered, idles high
//   inta_ready  interrupt request: IE & ready
//
// Control register (CTRL_BASE):
//   bit0 ready   (holding register empty, read-only)
//   bit1 busy    (frame in progress, read-only)
//   bit2 overrun (sticky, cleared by writing 0 to bit2)
//   bit8 IE      (interrupt enable)
// -----------------------------------------------------------------------------
module serial_tx #(
    parameter int               BITS         = 32,
    parameter int               DATA_WIDTH   = 8,
    parameter logic [BITS-1:0]  BASE         = 32'hF0000020,
    parameter logic [BITS-1:0]  CTRL_BASE    = 32'hF0000120,
    parameter int               CLKS_PER_BIT = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we,
    input  logic            re,
    input  logic [BITS-1:0] memAddr,
    input  logic [BITS-1:0] dataBusIn,
    output logic [BITS-1:0] dataBusOut,
    output logic            txd,
    output logic            inta_ready
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } txState_t;

    // Registered state
    txState_t              state_r;
    logic [BAUD_W-1:0]     baudCnt_r;
    logic [BIT_W-1:0]      bitCnt_r;
    logic [DATA_WIDTH-1:0] shifter_r;
    logic [DATA_WIDTH-1:0] holdReg_r;
    logic                  txd_r;
    logic                  busy_r;
    logic                  ready_r;
    logic                  overrun_r;
    logic                  ie_r;

    // Next-state values
    txState_t              nextState_s;
    logic [BAUD_W-1:0]     nextBaudCnt_s;
    logic [BIT_W-1:0]      nextBitCnt_s;
    logic [DATA_WIDTH-1:0] nextShifter_s;
    logic [DATA_WIDTH-1:0] nextHoldReg_s;
    logic                  nextTxd_s;
    logic                  nextBusy_s;
    logic                  nextReady_s;
    logic                  nextOverrun_s;
    logic                  nextIe_s;
    logic                  transfer_s;

    // Bus decode
    logic                  dataWr_s;
    logic                  ctrlWr_s;
    logic                  dataRd_s;
    logic                  ctrlRd_s;
    logic                  baudEnd_s;
    logic [DATA_WIDTH-1:0] shiftedByOne_s;
    logic [BITS-1:0]       ctrlWord_s;
    logic [BITS-1:0]       holdExt_s;
    logic                  unusedBus_s;

    assign dataWr_s  = we && (memAddr == BASE);
    assign ctrlWr_s  = we && (memAddr == CTRL_BASE);
    assign dataRd_s  = re && !we && (memAddr == BASE);
    assign ctrlRd_s  = re && !we && (memAddr == CTRL_BASE);
    assign baudEnd_s = (baudCnt_r == BAUD_LAST);
    assign shiftedByOne_s = shifter_r >> 1'b1;

    assign ctrlWord_s = BITS'({ie_r, 5'b00000, overrun_r, busy_r, ready_r});
    assign holdExt_s  = BITS'(holdReg_r);

    // Only a few write-data bits are meaningful; fold the rest so they count as consumed.
    assign unusedBus_s = ^dataBusIn;

    assign txd        = txd_r;
    assign inta_ready = ie_r & ready_r;

    // Read-data multiplexer; unmapped or write-qualified reads return zero.
    always_comb begin
        dataBusOut = '0;
        if (dataRd_s) begin
            dataBusOut = holdExt_s;
        end else if (ctrlRd_s) begin
            dataBusOut = ctrlWord_s;
        end else begin
            dataBusOut = '0;
        end
    end

    // Next-state logic: frame sequencing, holding-register handshake and control bits.
    always_comb begin
        nextState_s   = state_r;
        nextBaudCnt_s = baudCnt_r;
        nextBitCnt_s  = bitCnt_r;
        nextShifter_s = shifter_r;
        nextHoldReg_s = holdReg_r;
        nextTxd_s     = txd_r;
        nextBusy_s    = busy_r;
        nextReady_s   = ready_r;
        nextOverrun_s = overrun_r;
        nextIe_s      = ie_r;
        transfer_s    = 1'b0;

        case (state_r)
            IDLE: begin
                nextTxd_s  = 1'b1;
                nextBusy_s = 1'b0;
                if (!ready_r) begin
                    transfer_s = 1'b1;
                end else begin
                    nextState_s = IDLE;
                end
            end
            START: begin
                if (baudEnd_s) begin
                    nextBaudCnt_s = '0;
                    nextBitCnt_s  = '0;
                    nextState_s   = DATA;
                    nextTxd_s     = shifter_r[0];
                end else begin
                    nextBaudCnt_s = baudCnt_r + BAUD_W'(1);
                end
            end
            DATA: begin
                if (baudEnd_s) begin
                    nextBaudCnt_s = '0;
                    if (bitCnt_r == BIT_LAST) begin
                        nextState_s = STOP;
                        nextTxd_s   = 1'b1;
                    end else begin
                        nextBitCnt_s  = bitCnt_r + BIT_W'(1);
                        nextShifter_s = shiftedByOne_s;
                        nextTxd_s     = shiftedByOne_s[0];
                    end
                end else begin
                    nextBaudCnt_s = baudCnt_r + BAUD_W'(1);
                end
            end
            STOP: begin
                if (baudEnd_s) begin
                    nextBaudCnt_s = '0;
                    if (!ready_r) begin
                        // A payload is already waiting: chain straight into its start bit.
                        transfer_s = 1'b1;
                    end else begin
                        nextState_s = IDLE;
                        nextBusy_s  = 1'b0;
                        nextTxd_s   = 1'b1;
                    end
                end else begin
                    nextBaudCnt_s = baudCnt_r + BAUD_W'(1);
                end
            end
            default: begin
                nextState_s   = IDLE;
                nextBaudCnt_s = '0;
                nextBitCnt_s  = '0;
                nextTxd_s     = 1'b1;
                nextBusy_s    = 1'b0;
            end
        endcase

        // Holding-to-shifter transfer launches a frame with its start bit.
        if (transfer_s) begin
            nextShifter_s = holdReg_r;
            nextState_s   = START;
            nextBaudCnt_s = '0;
            nextBitCnt_s  = '0;
            nextTxd_s     = 1'b0;
            nextBusy_s    = 1'b1;
        end else begin
            nextShifter_s = nextShifter_s;
        end

        // A transfer needs ready=0 and an accepted write needs ready=1, so they never collide.
        if (transfer_s) begin
            nextReady_s = 1'b1;
        end else if (dataWr_s && ready_r) begin
            nextReady_s   = 1'b0;
            nextHoldReg_s = dataBusIn[DATA_WIDTH-1:0];
        end else begin
            nextReady_s = ready_r;
        end

        // A rejected data write sets overrun and takes priority over a clearing control write.
        if (dataWr_s && !ready_r) begin
            nextOverrun_s = 1'b1;
        end else if (ctrlWr_s && !dataBusIn[2]) begin
            nextOverrun_s = 1'b0;
        end else begin
            nextOverrun_s = overrun_r;
        end

        if (ctrlWr_s) begin
            nextIe_s = dataBusIn[8];
        end else begin
            nextIe_s = ie_r;
        end
    end

    // State register with asynchronous reset; a frame cut by reset is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            baudCnt_r <= '0;
            bitCnt_r  <= '0;
            shifter_r <= '0;
            holdReg_r <= '0;
            txd_r     <= 1'b1;
            busy_r    <= 1'b0;
            ready_r   <= 1'b1;
            overrun_r <= 1'b0;
            ie_r      <= 1'b0;
        end else begin
            state_r   <= nextState_s;
            baudCnt_r <= nextBaudCnt_s;
            bitCnt_r  <= nextBitCnt_s;
            shifter_r <= nextShifter_s;
            holdReg_r <= nextHoldReg_s;
            txd_r     <= nextTxd_s;
            busy_r    <= nextBusy_s;
            ready_r   <= nextReady_s;
            overrun_r <= nextOverrun_s;
            ie_r      <= nextIe_s;
        end
    end

endmodule

// File: tb/tb_serial_tx.sv
// -----------------------------------------------------------------------------
// tb_serial_tx -- directed self-checking bench for serial_tx with DATA_WIDTH=8
// and CLKS_PER_BIT=4. Cycle numbering: the cycle in which a write strobe is
// presented is cycle 0. Values are sampled 1 time unit after each rising edge,
// and the sample after the edge that ends cycle k-1 is the value in cycle k.
// -----------------------------------------------------------------------------
module tb_serial_tx;

    localparam logic [31:0] BASE_A = 32'hF0000020;
    localparam logic [31:0] CTRL_A = 32'hF0000120;

    logic        clk;
    logic        reset;
    logic        we;
    logic        re;
    logic [31:0] memAddr;
    logic [31:0] dataBusIn;
    logic [31:0] dataBusOut;
    logic        txd;
    logic        inta_ready;

    int total;
    int bad;
    int cyc;

    serial_tx #(
        .BITS(32),
        .DATA_WIDTH(8),
        .BASE(32'hF0000020),
        .CTRL_BASE(32'hF0000120),
        .CLKS_PER_BIT(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .we(we),
        .re(re),
        .memAddr(memAddr),
        .dataBusIn(dataBusIn),
        .dataBusOut(dataBusOut),
        .txd(txd),
        .inta_ready(inta_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected line level at offset rel from the start bit of a frame carrying d.
    function automatic logic expTxd(input logic [7:0] d, input int rel);
        if (rel < 0 || rel >= 40) return 1'b1;
        if (rel < 4) return 1'b0;
        if (rel < 36) return d[(rel - 4) / 4];
        return 1'b1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic busIdle();
        we        = 1'b0;
        re        = 1'b0;
        memAddr   = 32'h0;
        dataBusIn = 32'h0;
    endtask

    task automatic doWrite(input logic [31:0] a, input logic [31:0] d);
        we        = 1'b1;
        memAddr   = a;
        dataBusIn = d;
        tick();
        busIdle();
    endtask

    task automatic readReg(input logic [31:0] a, output logic [31:0] v);
        re      = 1'b1;
        memAddr = a;
        #1;
        v       = dataBusOut;
        re      = 1'b0;
        memAddr = 32'h0;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        reset = 1'b1;
        busIdle();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (txd !== 1'b1) begin bad++; $display("FAIL reset_txd got=%b exp=1", txd); end
        readReg(CTRL_A, v);
        total++;
        if (v !== 32'h1) begin bad++; $display("FAIL reset_ctrl got=%h exp=00000001", v); end
        readReg(BASE_A, v);
        total++;
        if (v !== 32'h0) begin bad++; $display("FAIL reset_data got=%h exp=00000000", v); end
        total++;
        if (inta_ready !== 1'b0) begin bad++; $display("FAIL reset_inta got=%b exp=0", inta_ready); end
        reset = 1'b0;
        tick();
    endtask

    // Full 0xA5 frame right after reset: checks line level and busy every cycle.
    task automatic test_frame();
        logic [31:0] v;
        cyc = 0;
        doWrite(BASE_A, 32'h000000A5);
        while (cyc <= 42) begin
            total++;
            if (txd !== expTxd(8'hA5, cyc - 2)) begin
                bad++; $display("FAIL frame_txd cyc=%0d got=%b exp=%b", cyc, txd, expTxd(8'hA5, cyc - 2));
            end
            readReg(CTRL_A, v);
            total++;
            if (v[1] !== ((cyc >= 2) && (cyc <= 41))) begin
                bad++; $display("FAIL frame_busy cyc=%0d got=%b exp=%b", cyc, v[1], (cyc >= 2) && (cyc <= 41));
            end
            tick();
        end
        readReg(BASE_A, v);
        total++;
        if (v !== 32'h000000A5) begin bad++; $display("FAIL frame_hold got=%h exp=000000a5", v); end
    endtask

    task automatic test_illegal_read();
        logic [31:0] v;
        we        = 1'b1;
        re        = 1'b1;
        memAddr   = BASE_A;
        dataBusIn = 32'h000000FF;
        #1;
        total++;
        if (dataBusOut !== 32'h0) begin bad++; $display("FAIL rd_with_we got=%h exp=00000000", dataBusOut); end
        busIdle();
        re      = 1'b1;
        memAddr = BASE_A + 32'h4;
        #1;
        total++;
        if (dataBusOut !== 32'h0) begin bad++; $display("FAIL rd_unmapped got=%h exp=00000000", dataBusOut); end
        busIdle();
        doWrite(32'h00001234, 32'h00000104);
        tick();
        readReg(CTRL_A, v);
        total++;
        if (v !== 32'h1) begin bad++; $display("FAIL unmapped_nochange_ctrl got=%h exp=00000001", v); end
        readReg(BASE_A, v);
        total++;
        if (v !== 32'h000000A5) begin bad++; $display("FAIL unmapped_nochange_data got=%h exp=000000a5", v); end
    endtask

    // 0x01 then 0x02 while the first frame is in flight: second start bit follows first stop bit.
    task automatic test_back_to_back();
        logic [31:0] v;
        logic        e;
        cyc = 0;
        doWrite(BASE_A, 32'h00000001);
        tick();
        readReg(CTRL_A, v);
        total++;
        if (v !== 32'h3) begin bad++; $display("FAIL b2b_ctrl_c2 got=%h exp=00000003", v); end
        doWrite(BASE_A, 32'h00000002);
        while (cyc <= 82) begin
            e = (cyc < 42) ? expTxd(8'h01, cyc - 2) : expTxd(8'h02, cyc - 42);
            total++;
            if (txd !== e) begin bad++; $display("FAIL b2b_txd cyc=%0d got=%b exp=%b", cyc, txd, e); end
            readReg(CTRL_A, v);
            total++;
            if (v[0] !== (cyc >= 42)) begin bad++; $display("FAIL b2b_ready cyc=%0d got=%b exp=%b", cyc, v[0], cyc >= 42); end
            total++;
            if (v[2] !== 1'b0) begin bad++; $display("FAIL b2b_overrun cyc=%0d got=%b exp=0", cyc, v[2]); end
            tick();
        end
    endtask

    // 0x11, 0x22, 0x33 on consecutive cycles: 0x22 meets a full holding register and is dropped.
    task automatic test_overrun();
        logic [31:0] v;
        logic        e;
        cyc = 0;
        doWrite(BASE_A, 32'h00000011);
        doWrite(BASE_A, 32'h00000022);
        doWrite(BASE_A, 32'h00000033);
        readReg(CTRL_A, v);
        total++;
        if (v !== 32'h6) begin bad++; $display("FAIL ovr_ctrl got=%h exp=00000006", v); end
        readReg(BASE_A, v);
        total++;
        if (v !== 32'h33) begin bad++; $display("FAIL ovr_hold got=%h exp=00000033", v); end
        doWrite(CTRL_A, 32'h00000004);
        readReg(CTRL_A, v);
        total++;
        if (v !== 32'h6) begin bad++; $display("FAIL ovr_keep got=%h exp=00000006", v); end
        doWrite(CTRL_A, 32'h00000000);
        readReg(CTRL_A, v);
        total++;
        if (v !== 32'h2) begin bad++; $display("FAIL ovr_clear got=%h exp=00000002", v); end
        while (cyc <= 82) begin
            e = (cyc < 42) ? expTxd(8'h11, cyc - 2) : expTxd(8'h33, cyc - 42);
            total++;
            if (txd !== e) begin bad++; $display("FAIL ovr_txd cyc=%0d got=%b exp=%b", cyc, txd, e); end
            tick();
        end
        readReg(CTRL_A, v);
        total++;
        if (v !== 32'h1) begin bad++; $display("FAIL ovr_end_ctrl got=%h exp=00000001", v); end
    endtask

    task automatic test_interrupt();
        logic [31:0] v;
        total++;
        if (inta_ready !== 1'b0) begin bad++; $display("FAIL irq_off got=%b exp=0", inta_ready); end
        cyc = 0;
        doWrite(CTRL_A, 32'h00000100);
        total++;
        if (inta_ready !== 1'b1) begin bad++; $display("FAIL irq_on got=%b exp=1", inta_ready); end
        readReg(CTRL_A, v);
        total++;
        if (v !== 32'h101) begin bad++; $display("FAIL irq_ctrl got=%h exp=00000101", v); end
        doWrite(BASE_A, 32'h0000005A);
        total++;
        if (inta_ready !== 1'b0) begin bad++; $display("FAIL irq_after_wr got=%b exp=0", inta_ready); end
        tick();
        total++;
        if (inta_ready !== 1'b1) begin bad++; $display("FAIL irq_transfer got=%b exp=1", inta_ready); end
        total++;
        if (txd !== 1'b0) begin bad++; $display("FAIL irq_start got=%b exp=0", txd); end
        while (cyc < 43) tick();
        readReg(CTRL_A, v);
        total++;
        if (v !== 32'h101) begin bad++; $display("FAIL irq_end_ctrl got=%h exp=00000101", v); end
        doWrite(CTRL_A, 32'h00000000);
        total++;
        if (inta_ready !== 1'b0) begin bad++; $display("FAIL irq_disable got=%b exp=0", inta_ready); end
    endtask

    // Reset in cycle 20 of a frame, then a fresh 0xC3 frame with normal timing.
    task automatic test_reset_midframe();
        logic [31:0] v;
        cyc = 0;
        doWrite(BASE_A, 32'h0000003C);
        while (cyc < 20) tick();
        total++;
        if (txd !== 1'b1) begin bad++; $display("FAIL mid_pre_txd got=%b exp=1", txd); end
        #1;
        reset = 1'b1;
        #1;
        total++;
        if (txd !== 1'b1) begin bad++; $display("FAIL mid_rst_txd got=%b exp=1", txd); end
        readReg(CTRL_A, v);
        total++;
        if (v !== 32'h1) begin bad++; $display("FAIL mid_rst_ctrl got=%h exp=00000001", v); end
        readReg(BASE_A, v);
        total++;
        if (v !== 32'h0) begin bad++; $display("FAIL mid_rst_hold got=%h exp=00000000", v); end
        #1;
        reset = 1'b0;
        tick();
        cyc = 0;
        doWrite(BASE_A, 32'h000000C3);
        while (cyc <= 42) begin
            total++;
            if (txd !== expTxd(8'hC3, cyc - 2)) begin
                bad++; $display("FAIL mid_frame_txd cyc=%0d got=%b exp=%b", cyc, txd, expTxd(8'hC3, cyc - 2));
            end
            tick();
        end
        readReg(CTRL_A, v);
        total++;
        if (v !== 32'h1) begin bad++; $display("FAIL mid_end_ctrl got=%h exp=00000001", v); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;
        reset = 1'b1;
        busIdle();
        test_reset();
        test_frame();
        test_illegal_read();
        test_back_to_back();
        test_overrun();
        test_interrupt();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "simulation time limit reached");
    end

endmodule
